maxpool_grad_router: RTL and testbench
======================================

// Module: maxpool_grad_router
// PURPOSE
//  Backward max-pool stage of the training pipeline; sits between FC backward and conv backward.
//  Consumes one gradient per pooled output, in raster order.
//  Re-reads the forward feature map, finds each window's argmax, and writes a full-size gradient map.
//  Each window's argmax position receives the incoming gradient; the other window positions receive 0.
// PARAMETERS
//  FM_HEIGHT  62  feature-map rows; must be a multiple of POOL (elaboration $error otherwise)
//  FM_WIDTH   62  feature-map cols; must be a multiple of POOL (elaboration $error otherwise)
//  POOL       2   window side; stride == POOL
//  DATA_W     16  feature-map and gradient width, signed two's complement
//  ADDR_W     12  address width; must satisfy 2**ADDR_W >= FM_HEIGHT*FM_WIDTH
// PORTS
//  clk         in   1       single clock, rising edge
//  rst         in   1       synchronous, active-high reset
//  start       in   1       1-cycle pulse; starts a pass; ignored while busy
//  busy        out  1       high from the cycle after start until done
//  done        out  1       1-cycle pulse after the last gradient write
//  fm_rd_addr  out  ADDR_W  feature-map read address, row*FM_WIDTH+col
//  fm_rd_en    out  1       read strobe; fm_rd_data is valid exactly 1 cycle later
//  fm_rd_data  in   DATA_W  forward feature-map value
//  grad_valid  in   1       pooled-gradient beat available
//  grad_ready  out  1       high only in state GRAD
//  grad_data   in   DATA_W  pooled gradient; taken when grad_valid&&grad_ready
//  gout_we     out  1       gradient-map write enable
//  gout_addr   out  ADDR_W  gradient-map address, row*FM_WIDTH+col
//  gout_data   out  DATA_W  gradient value to write
// BEHAVIOUR
//  Reset: every output is 0 and state=IDLE. rst mid-pass aborts the pass immediately: no further reads or writes, no done pulse.
//  Windows are processed in raster order (pr,pc); positions inside a window are visited row-major (k=0..POOL*POOL-1).
//  IDLE: on start, clear the window counters, set busy, go to READ.
//  READ: POOL*POOL cycles, one fm_rd_en per cycle at window position k.
//    Read data arriving for k>0 is compared in the cycle it arrives.
//  LAST: one cycle to absorb the final read's data.
//  Argmax rule:
//    - Signed compare.
//    - k=0 initialises max and arg.
//    - A later value replaces max only if strictly greater, so on ties the first position in scan order wins.
//  GRAD: grad_ready=1. On a handshake, latch grad_data and go to WRITE. Otherwise wait; stalls are unbounded.
//  WRITE: POOL*POOL cycles, gout_we=1 in every cycle.
//    gout_data=grad at k==arg, else 0.
//    Every feature-map location is written exactly once per pass.
//  NEXT (folded into the last WRITE cycle):
//    - If the window just finished was not the last one, advance the window and go to READ.
//    - Otherwise go to IDLE, pulse done, drop busy.
//  Timing: with grad_valid held high, each window takes 2*POOL^2+2 cycles.
//    Total = (FM_HEIGHT/POOL)*(FM_WIDTH/POOL)*(2*POOL^2+2) cycles from the first READ cycle to the last write.
//    done asserts the following cycle.
//  Read and write never overlap. Exactly one grad beat is consumed per window; no grad is accepted outside GRAD.
//  A start coincident with done's cycle is ignored; start is accepted only in IDLE.
// STRUCTURE
//  Shared package cnn_pkg: DATA_W default and a state enum localparam set.
//  Also in cnn_pkg: function fm_addr(row,col,width).
//  Sub-module pool_argmax_tracker:
//    - Inputs: clk, rst, clear, v_valid, v_data, v_idx.
//    - Outputs: max_val, max_idx.
//    - Holds the strict-greater, first-wins logic.
//  The top holds the FSM, the window/position counters, and the address generation.
// TESTING (FM 4x4, POOL=2 unless noted; fm[r][c]=r*4+c)
//  1 Ascending map, grads 5,6,7,8 always valid.
//    - Non-zero writes: addr5=5, addr7=6, addr13=7, addr15=8; the other 12 addresses are written 0.
//    - done pulses at cycle 41 after start.
//  2 Negative values: window0 = -3,-1,-7,-2.
//    - Argmax is addr1; the other three positions get 0.
//  3 Ties: window0 all 9.
//    - Gradient goes to addr0 only (first-wins).
//  4 Backpressure: grad_valid held low for 7 cycles in each GRAD.
//    - grad_ready stays high and no writes occur during the stall.
//    - Total 40+4*7 cycles; results are identical to test 1.
//  5 rst pulsed during the WRITE of window 1.
//    - All outputs are 0 the next cycle; no done.
//    - A new start gives the full test-1 result.
//  6 start re-pulsed while busy, and again in the done cycle.
//    - Ignored: exactly 16 writes and one done.

Source files
------------

// File: rtl/cnn_pkg.sv
// cnn_pkg: shared widths, FSM state encoding and feature-map address helper
package cnn_pkg;
    localparam int CNN_DATA_W = 16;
    typedef enum logic [2:0] {S_IDLE, S_READ, S_LAST, S_GRAD, S_WRITE} state_t;
    function automatic int fm_addr(input int row, input int col, input int width);
        return row * width + col;
    endfunction
endpackage

// File: rtl/pool_argmax_tracker.sv
// pool_argmax_tracker: running signed max over one window, first position wins on ties
module pool_argmax_tracker
    import cnn_pkg::*;
#(
    parameter int DATA_W = CNN_DATA_W,
    parameter int IDX_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              v_valid,
    input  logic [DATA_W-1:0] v_data,
    input  logic [IDX_W-1:0]  v_idx,
    output logic [DATA_W-1:0] max_val,
    output logic [IDX_W-1:0]  max_idx
);
    logic [DATA_W-1:0] r_max;
    logic [IDX_W-1:0]  r_idx;
    logic              w_take;
    assign w_take  = v_valid && (v_idx == '0 || $signed(v_data) > $signed(r_max));
    assign max_val = r_max;
    assign max_idx = r_idx;
    // position 0 seeds the window; later values win only when strictly greater
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_max <= '0;
            r_idx <= '0;
        end else if (w_take) begin
            r_max <= v_data;
            r_idx <= v_idx;
        end
    end
endmodule

// File: rtl/maxpool_grad_router.sv
// maxpool_grad_router: routes each pooled gradient to its window's argmax in a full-size map
module maxpool_grad_router
    import cnn_pkg::*;
#(
    parameter int FM_HEIGHT = 62,
    parameter int FM_WIDTH  = 62,
    parameter int POOL      = 2,
    parameter int DATA_W    = CNN_DATA_W,
    parameter int ADDR_W    = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] fm_rd_addr,
    output logic              fm_rd_en,
    input  logic [DATA_W-1:0] fm_rd_data,
    input  logic              grad_valid,
    output logic              grad_ready,
    input  logic [DATA_W-1:0] grad_data,
    output logic              gout_we,
    output logic [ADDR_W-1:0] gout_addr,
    output logic [DATA_W-1:0] gout_data
);
    localparam int K_N = POOL * POOL;
    localparam int K_W = (K_N > 1) ? $clog2(K_N) : 1;
    localparam logic [K_W-1:0]    K_LAST  = K_W'(K_N - 1);
    localparam logic [ADDR_W-1:0] PR_LAST = ADDR_W'(FM_HEIGHT / POOL - 1);
    localparam logic [ADDR_W-1:0] PC_LAST = ADDR_W'(FM_WIDTH / POOL - 1);

    if (FM_HEIGHT % POOL != 0 || FM_WIDTH % POOL != 0) begin : g_bad_dims
        $error("FM_HEIGHT and FM_WIDTH must be multiples of POOL");
    end
    if ((1 << ADDR_W) < FM_HEIGHT * FM_WIDTH) begin : g_bad_addr
        $error("ADDR_W too small for the feature map");
    end

    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_pr, r_pc, w_addr;
    logic [K_W-1:0]    r_k, r_rd_k, w_arg;
    logic [DATA_W-1:0] r_grad, w_unused_max;
    logic              r_rd_v, r_done, w_k_last, w_win_last;

    assign w_k_last   = r_k == K_LAST;
    assign w_win_last = r_pr == PR_LAST && r_pc == PC_LAST;
    assign w_addr     = ADDR_W'(fm_addr(int'(r_pr) * POOL + int'(r_k) / POOL,
                                        int'(r_pc) * POOL + int'(r_k) % POOL, FM_WIDTH));

    assign busy       = r_state != S_IDLE;
    assign done       = r_done;
    assign fm_rd_en   = r_state == S_READ;
    assign fm_rd_addr = fm_rd_en ? w_addr : '0;
    assign grad_ready = r_state == S_GRAD;
    assign gout_we    = r_state == S_WRITE;
    assign gout_addr  = gout_we ? w_addr : '0;
    assign gout_data  = (gout_we && r_k == w_arg) ? r_grad : '0;

    pool_argmax_tracker #(.DATA_W(DATA_W), .IDX_W(K_W)) u_tracker (
        .clk    (clk),
        .rst    (rst),
        .clear  (r_state == S_IDLE),
        .v_valid(r_rd_v),
        .v_data (fm_rd_data),
        .v_idx  (r_rd_k),
        .max_val(w_unused_max),
        .max_idx(w_arg)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // next state; a start landing on the done cycle is dropped
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start && !r_done) w_next = S_READ;
            S_READ:  if (w_k_last) w_next = S_LAST;
            S_LAST:  w_next = S_GRAD;
            S_GRAD:  if (grad_valid) w_next = S_WRITE;
            S_WRITE: if (w_k_last) w_next = w_win_last ? S_IDLE : S_READ;
            default: w_next = S_IDLE;
        endcase
    end

    // window/position counters, read-data tagging, gradient latch and done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pr   <= '0;
            r_pc   <= '0;
            r_k    <= '0;
            r_rd_k <= '0;
            r_rd_v <= 1'b0;
            r_grad <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= r_state == S_WRITE && w_k_last && w_win_last;
            r_rd_v <= r_state == S_READ;
            r_rd_k <= r_k;
            if (r_state == S_IDLE) begin
                r_pr <= '0;
                r_pc <= '0;
                r_k  <= '0;
            end else if (r_state == S_READ || r_state == S_WRITE) begin
                r_k <= w_k_last ? '0 : r_k + 1'b1;
            end
            if (r_state == S_GRAD && grad_valid) r_grad <= grad_data;
            if (r_state == S_WRITE && w_k_last && !w_win_last) begin
                r_pc <= (r_pc == PC_LAST) ? '0 : r_pc + 1'b1;
                if (r_pc == PC_LAST) r_pr <= r_pr + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_maxpool_grad_router.sv
// tb_maxpool_grad_router: randomized and directed checks of the 4x4 / POOL=2 router against a window-argmax model
module tb_maxpool_grad_router;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, fm_rd_en, grad_ready, gout_we;
    logic [3:0]  fm_rd_addr, gout_addr;
    logic [15:0] fm_rd_data = '0;
    logic        grad_valid = 1'b0;
    logic [15:0] grad_data = '0;
    logic [15:0] gout_data;

    maxpool_grad_router #(.FM_HEIGHT(4), .FM_WIDTH(4), .POOL(2), .DATA_W(16), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .fm_rd_addr(fm_rd_addr), .fm_rd_en(fm_rd_en), .fm_rd_data(fm_rd_data),
        .grad_valid(grad_valid), .grad_ready(grad_ready), .grad_data(grad_data),
        .gout_we(gout_we), .gout_addr(gout_addr), .gout_data(gout_data)
    );

    always #5 clk = ~clk;

    logic signed [15:0] fm [16];
    logic signed [15:0] g [4];
    logic [15:0] exp_w [16];
    int exp_rd [16];
    int got [16];
    int written [16];
    int checks = 0, passes = 0;
    int pass_id = 0, rd_n = 0, wcnt = 0, dcnt = 0, hs = 0, hs0 = 0;
    int stall = 0, wait_cnt = 0;
    bit pend_v = 0, last_ready = 0;
    int pend_a = 0;

    task automatic check(input bit ok, input string name, input int act, input int req);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    // spec-level model: per window, first strict maximum in scan order gets the gradient
    task automatic build_model();
        for (int w = 0; w < 4; w++) begin
            int a [4];
            int best;
            best = 0;
            for (int k = 0; k < 4; k++) begin
                a[k] = ((w / 2) * 2 + k / 2) * 4 + (w % 2) * 2 + k % 2;
                exp_rd[w * 4 + k] = a[k];
            end
            for (int k = 1; k < 4; k++) if (fm[a[k]] > fm[a[best]]) best = k;
            for (int k = 0; k < 4; k++) exp_w[a[k]] = (k == best) ? g[w] : 16'd0;
        end
    endtask

    // one clock: memory response, gradient source and all per-cycle output checks
    task automatic tick();
        @(negedge clk);
        if (!rst && last_ready) begin
            if (grad_valid) hs++;
            else check(grad_ready, "ready_hold", int'(grad_ready), 1);
        end
        fm_rd_data = pend_v ? fm[pend_a] : 16'($urandom);
        pend_v = fm_rd_en;
        pend_a = int'(fm_rd_addr);
        if (fm_rd_en) begin
            check(!gout_we && !grad_ready, "read_excl", int'(gout_we), 0);
            check(rd_n < 16 && int'(fm_rd_addr) == exp_rd[rd_n % 16], "read_addr",
                  int'(fm_rd_addr), rd_n < 16 ? exp_rd[rd_n] : -1);
            rd_n++;
        end
        if (gout_we) begin
            check(!grad_ready, "write_excl", int'(grad_ready), 0);
            check(written[gout_addr] != pass_id, "write_once", int'(gout_addr), -1);
            check(gout_data == exp_w[gout_addr], "write_data", int'(gout_data), int'(exp_w[gout_addr]));
            written[gout_addr] = pass_id;
            got[gout_addr] = int'($signed(gout_data));
            wcnt++;
        end
        if (done) dcnt++;
        grad_valid = grad_ready && wait_cnt >= stall;
        wait_cnt = grad_ready ? wait_cnt + 1 : 0;
        grad_data = g[(hs - hs0) & 3];
        last_ready = grad_ready;
    endtask

    task automatic begin_pass(input int stall_in);
        stall = stall_in;
        build_model();
        pass_id++;
        rd_n = 0;
        hs0 = hs;
        for (int a = 0; a < 16; a++) got[a] = -99999;
    endtask

    task automatic run_pass(input int stall_in, input bit repulse, input int exp_cyc);
        int n, w0, d0, all;
        begin_pass(stall_in);
        w0 = wcnt;
        d0 = dcnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        check(busy, "busy_rise", int'(busy), 1);
        while (!done && n < 600) begin
            if (repulse && n == 10) start = 1'b1;
            tick();
            start = 1'b0;
            n++;
        end
        check(done && n == exp_cyc, "done_cycle", n, exp_cyc);
        check(!busy, "busy_fall", int'(busy), 0);
        if (repulse) start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check(!busy && rd_n == 16, "idle_after_done", rd_n, 16);
        check(wcnt - w0 == 16, "write_count", wcnt - w0, 16);
        check(dcnt - d0 == 1, "done_count", dcnt - d0, 1);
        check(hs - hs0 == 4, "grad_beats", hs - hs0, 4);
        all = 0;
        for (int a = 0; a < 16; a++) all += (written[a] == pass_id) ? 1 : 0;
        check(all == 16, "coverage", all, 16);
    endtask

    task automatic ascending();
        for (int a = 0; a < 16; a++) fm[a] = 16'(a);
        for (int w = 0; w < 4; w++) g[w] = 16'(5 + w);
    endtask

    task automatic pin_ascending();
        int others;
        check(got[5] == 5, "pin_addr5", got[5], 5);
        check(got[7] == 6, "pin_addr7", got[7], 6);
        check(got[13] == 7, "pin_addr13", got[13], 7);
        check(got[15] == 8, "pin_addr15", got[15], 8);
        others = 0;
        for (int a = 0; a < 16; a++) if (a != 5 && a != 7 && a != 13 && a != 15 && got[a] != 0) others++;
        check(others == 0, "pin_zeros", others, 0);
    endtask

    initial begin
        int n, r0, w0, d0, st;
        ascending();
        build_model();
        repeat (3) tick();
        check({busy, done, fm_rd_en, fm_rd_addr, grad_ready, gout_we, gout_addr, gout_data} == '0,
              "reset_outputs", int'(busy), 0);
        rst = 1'b0;
        tick();

        run_pass(0, 0, 41);
        pin_ascending();

        ascending();
        fm[0] = -16'sd3; fm[1] = -16'sd1; fm[4] = -16'sd7; fm[5] = -16'sd2;
        run_pass(0, 0, 41);
        check(got[1] == 5 && got[0] == 0 && got[4] == 0 && got[5] == 0, "pin_negative", got[1], 5);

        ascending();
        fm[0] = 16'sd9; fm[1] = 16'sd9; fm[4] = 16'sd9; fm[5] = 16'sd9;
        run_pass(0, 0, 41);
        check(got[0] == 5 && got[1] == 0 && got[4] == 0 && got[5] == 0, "pin_ties", got[0], 5);

        ascending();
        run_pass(7, 0, 41 + 4 * 7);
        pin_ascending();

        for (int it = 0; it < 6; it++) begin
            for (int a = 0; a < 16; a++) fm[a] = (it % 2 == 0) ? 16'($urandom_range(0, 6)) - 16'sd3 : 16'($urandom);
            for (int w = 0; w < 4; w++) g[w] = 16'($urandom);
            st = $urandom_range(0, 3);
            run_pass(st, 0, 41 + 4 * st);
        end

        ascending();
        begin_pass(0);
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!(gout_we && gout_addr == 4'd2) && n < 200) begin
            tick();
            n++;
        end
        check(n < 200, "reach_window1_write", n, 200);
        rst = 1'b1;
        tick();
        check({busy, done, fm_rd_en, fm_rd_addr, grad_ready, gout_we, gout_addr, gout_data} == '0,
              "abort_outputs", int'(busy), 0);
        rst = 1'b0;
        r0 = rd_n;
        w0 = wcnt;
        d0 = dcnt;
        for (int i = 0; i < 10; i++) tick();
        check(rd_n == r0 && wcnt == w0 && dcnt == d0 && !busy, "abort_quiet", wcnt - w0, 0);
        run_pass(0, 0, 41);
        pin_ascending();

        run_pass(0, 1, 41);
        pin_ascending();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
